// File: rtl/adder_pipe_n_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe_n_if
// Brief    : Operand/result bundle with valid/ready flow control on both sides.
// Revision : 1.0
// ============================================================================
interface adder_pipe_n_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         Cin;
   logic         Sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] Sum;
   logic         Cout;
   logic         Ovf;

   modport master (
      output in_valid, A, B, Cin, Sub, out_ready,
      input  in_ready, out_valid, Sum, Cout, Ovf
   );

   modport slave (
      input  in_valid, A, B, Cin, Sub, out_ready,
      output in_ready, out_valid, Sum, Cout, Ovf
   );
endinterface
`default_nettype wire

// File: rtl/adder_pipe_n.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe_n
// Brief    : Pipelined N-bit add/subtract, carry chain split into STAGES slices.
// Revision : 1.0
// ============================================================================
module adder_pipe_n #(
   parameter int N      = 32,
   parameter int STAGES = 4
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   adder_pipe_n_if.slave bus
);
   localparam int c_W = N / STAGES;

   // Registered contents of every stage, exposed so the next stage can read them.
   logic         w_vld_q [STAGES];
   logic         w_c_q   [STAGES];
   logic [N-1:0] w_a_q   [STAGES];
   logic [N-1:0] w_b_q   [STAGES];
   logic [N-1:0] w_sum_q [STAGES];

   logic         w_adv;
   logic [N-1:0] w_b_eff;
   logic         w_c0;

   assign w_adv   = !w_vld_q[STAGES-1] || bus.out_ready;
   assign w_b_eff = bus.Sub ? ~bus.B : bus.B;
   assign w_c0    = bus.Sub ? ~bus.Cin : bus.Cin;

   generate
      for (genvar k = 0; k < STAGES; k++) begin : g_stage
         logic         w_vld_p;
         logic         w_c_p;
         logic [N-1:0] w_a_p;
         logic [N-1:0] w_b_p;
         logic [N-1:0] w_sum_p;
         logic [c_W:0] w_slice;
         logic [N-1:0] w_sum_n;

         logic         r_vld;
         logic         r_c;
         logic [N-1:0] r_a;
         logic [N-1:0] r_b;
         logic [N-1:0] r_sum;

         if (k == 0) begin : g_head
            assign w_vld_p = bus.in_valid;
            assign w_c_p   = w_c0;
            assign w_a_p   = bus.A;
            assign w_b_p   = w_b_eff;
            assign w_sum_p = '0;
         end else begin : g_body
            assign w_vld_p = w_vld_q[k-1];
            assign w_c_p   = w_c_q[k-1];
            assign w_a_p   = w_a_q[k-1];
            assign w_b_p   = w_b_q[k-1];
            assign w_sum_p = w_sum_q[k-1];
         end

         assign w_slice = {1'b0, w_a_p[k*c_W +: c_W]}
                        + {1'b0, w_b_p[k*c_W +: c_W]}
                        + {{c_W{1'b0}}, w_c_p};

         // Lower slices arrive already summed; only slice k is produced here.
         always_comb begin
            w_sum_n                  = w_sum_p;
            w_sum_n[k*c_W +: c_W]    = w_slice[c_W-1:0];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_vld <= 1'b0;
               r_c   <= 1'b0;
               r_a   <= '0;
               r_b   <= '0;
               r_sum <= '0;
            end else if (w_adv) begin
               r_vld <= w_vld_p;
               r_c   <= w_slice[c_W];
               r_a   <= w_a_p;
               r_b   <= w_b_p;
               r_sum <= w_sum_n;
            end
         end

         assign w_vld_q[k] = r_vld;
         assign w_c_q[k]   = r_c;
         assign w_a_q[k]   = r_a;
         assign w_b_q[k]   = r_b;
         assign w_sum_q[k] = r_sum;
      end
   endgenerate

   assign bus.in_ready  = w_adv;
   assign bus.out_valid = w_vld_q[STAGES-1];
   assign bus.Sum       = w_sum_q[STAGES-1];
   assign bus.Cout      = w_c_q[STAGES-1];
   // Operand sign bits ride along to the last stage for the overflow test.
   assign bus.Ovf       = (w_a_q[STAGES-1][N-1] == w_b_q[STAGES-1][N-1])
                       && (w_sum_q[STAGES-1][N-1] != w_a_q[STAGES-1][N-1]);
endmodule
`default_nettype wire
